// File: rtl/dca_matrix_mreg2store_partial.sv
// Streams mreg head rows onto the store tensor-row read channel, always rotating the mreg
// a full MATRIX_NUM_ROW times per request. Define DCA_MREG2STORE_OUTPUT_REG_EN for a 2-entry output skid buffer.
module dca_matrix_mreg2store_partial #(
  parameter int MATRIX_SIZE_PARA = 4,
  parameter int BW_TENSOR_SCALAR = 32,
  localparam int MATRIX_NUM_ROW = MATRIX_SIZE_PARA,
  localparam int MATRIX_NUM_COL = MATRIX_SIZE_PARA,
  localparam int BW_TENSOR_ROW = MATRIX_NUM_COL * BW_TENSOR_SCALAR,
  localparam int BW_ROW_INDEX = (MATRIX_NUM_ROW > 1) ? $clog2(MATRIX_NUM_ROW) : 1,
  localparam int BW_POP = $clog2(MATRIX_NUM_ROW + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     enable,
  output logic                     busy,
  output logic                     storereg_wready,
  input  logic                     storereg_wrequest,
  input  logic [BW_ROW_INDEX-1:0]  storereg_wnum_row_m1,
  output logic                     mreg_move_renable,
  input  logic [BW_TENSOR_ROW-1:0] mreg_move_rdata_list1d,
  input  logic                     store_tensor_row_rvalid,
  input  logic                     store_tensor_row_rlast,
  output logic                     store_tensor_row_rready,
  output logic [BW_TENSOR_ROW-1:0] store_tensor_row_rdata,
  output logic                     status_pad,
  output logic                     status_trunc,
  output logic [1:0]               dbg_state
);

  // Handshake: a row moves on a clock edge where enable & rvalid & rready are all high;
  // rready never depends on rvalid, and rdata is zero whenever rready is low.

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAD = 2'd2, DRAIN = 2'd3} state_t;

  localparam logic [BW_POP-1:0] POP_MAX = BW_POP'(MATRIX_NUM_ROW);

  state_t              state_q, state_d;
  logic [BW_POP-1:0]   num_row_q;
  logic [BW_POP-1:0]   pop_q;
  logic [BW_POP-1:0]   sent_q;
  logic [BW_POP-1:0]   sent_inc;
  logic                status_pad_q, status_trunc_q;
  logic                accept, xfer, pop;
  logic                data_phase, pop_room;
  logic                run_avail, run_pop;
  logic [BW_TENSOR_ROW-1:0] run_data;

  assign accept     = (state_q == IDLE) && enable && storereg_wrequest;
  assign xfer       = enable && store_tensor_row_rvalid && store_tensor_row_rready;
  assign pop        = enable && mreg_move_renable;
  assign data_phase = (pop_q < num_row_q);
  assign pop_room   = (pop_q < POP_MAX);
  assign sent_inc   = sent_q + BW_POP'(1);

`ifdef DCA_MREG2STORE_OUTPUT_REG_EN
  logic [1:0]               buf_cnt_q;
  logic [BW_TENSOR_ROW-1:0] buf0_q, buf1_q;
  logic                     buf_push, buf_pull;

  assign run_avail = (buf_cnt_q != 2'd0);
  assign run_data  = buf0_q;
  // A data pop may land in a full buffer only when the head leaves on the same edge.
  assign run_pop   = pop_room && (data_phase ? ((buf_cnt_q != 2'd2) || xfer) : 1'b1);
  assign buf_push  = pop && (state_q == RUN) && data_phase;
  assign buf_pull  = xfer && (state_q == RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_cnt_q <= 2'd0;
      buf0_q    <= '0;
      buf1_q    <= '0;
    end else if (clear || ((state_q == RUN) && (state_d == DRAIN))) begin
      buf_cnt_q <= 2'd0;
    end else begin
      case ({buf_push, buf_pull})
        2'b10: begin
          if (buf_cnt_q == 2'd0) buf0_q <= mreg_move_rdata_list1d;
          else                   buf1_q <= mreg_move_rdata_list1d;
          buf_cnt_q <= buf_cnt_q + 2'd1;
        end
        2'b01: begin
          buf0_q    <= buf1_q;
          buf_cnt_q <= buf_cnt_q - 2'd1;
        end
        2'b11: begin
          if (buf_cnt_q == 2'd1) begin
            buf0_q <= mreg_move_rdata_list1d;
          end else begin
            buf0_q <= buf1_q;
            buf1_q <= mreg_move_rdata_list1d;
          end
        end
        default: ;
      endcase
    end
  end
`else
  assign run_avail = 1'b1;
  assign run_data  = mreg_move_rdata_list1d;
  // Without a buffer the head row is consumed exactly when it is transferred.
  assign run_pop   = pop_room && data_phase && xfer;
`endif

  always_comb begin
    store_tensor_row_rready = 1'b0;
    store_tensor_row_rdata  = '0;
    if (enable) begin
      case (state_q)
        RUN: begin
          store_tensor_row_rready = run_avail;
          if (run_avail) store_tensor_row_rdata = run_data;
        end
        PAD:     store_tensor_row_rready = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d           = state_q;
    mreg_move_renable = 1'b0;
    storereg_wready   = 1'b0;
    case (state_q)
      IDLE: begin
        storereg_wready = 1'b1;
        if (enable && storereg_wrequest) state_d = RUN;
      end
      RUN: begin
        mreg_move_renable = enable && run_pop;
        if (xfer && store_tensor_row_rlast) state_d = DRAIN;
        else if (xfer && (sent_inc == num_row_q)) state_d = PAD;
      end
      PAD: begin
        mreg_move_renable = enable && pop_room;
        if (xfer && store_tensor_row_rlast) state_d = DRAIN;
      end
      DRAIN: begin
        mreg_move_renable = enable && pop_room;
        if (enable && !pop_room) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      num_row_q      <= '0;
      pop_q          <= '0;
      sent_q         <= '0;
      status_pad_q   <= 1'b0;
      status_trunc_q <= 1'b0;
    end else if (clear) begin
      state_q        <= IDLE;
      num_row_q      <= '0;
      pop_q          <= '0;
      sent_q         <= '0;
      status_pad_q   <= 1'b0;
      status_trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        num_row_q      <= BW_POP'(storereg_wnum_row_m1) + BW_POP'(1);
        pop_q          <= '0;
        sent_q         <= '0;
        status_pad_q   <= 1'b0;
        status_trunc_q <= 1'b0;
      end else begin
        if (pop) pop_q <= pop_q + BW_POP'(1);
        if (xfer && (state_q == RUN)) begin
          sent_q <= sent_inc;
          if (store_tensor_row_rlast && (sent_inc < num_row_q)) status_trunc_q <= 1'b1;
        end
        if (xfer && (state_q == PAD)) status_pad_q <= 1'b1;
      end
    end
  end

  assign busy         = (state_q != IDLE);
  assign status_pad   = status_pad_q;
  assign status_trunc = status_trunc_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_dca_matrix_mreg2store_partial.sv
// Scoreboard bench for dca_matrix_mreg2store_partial with a rotating 4-row mreg model;
// builds with or without DCA_MREG2STORE_OUTPUT_REG_EN.
module tb_dca_matrix_mreg2store_partial;
  localparam int N  = 4;
  localparam int SW = 32;
  localparam int BW = N * SW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clear, enable, busy, wready, wrequest;
  logic [1:0]    wnum;
  logic          renable, rvalid, rlast, rready;
  logic [BW-1:0] mreg_rdata, rdata;
  logic          status_pad, status_trunc;
  logic [1:0]    dbg_state;

  logic [BW-1:0] exp_q[$];
  int            n_vec = 0;
  int            n_err = 0;
  int            pop_total = 0;
  int            xfer_total = 0;
  logic [1:0]    head = 2'd0;
  logic          mreg_reload;

  always #5 clk = ~clk;

  dca_matrix_mreg2store_partial #(.MATRIX_SIZE_PARA(N), .BW_TENSOR_SCALAR(SW)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .clear                   (clear),
    .enable                  (enable),
    .busy                    (busy),
    .storereg_wready         (wready),
    .storereg_wrequest       (wrequest),
    .storereg_wnum_row_m1    (wnum),
    .mreg_move_renable       (renable),
    .mreg_move_rdata_list1d  (mreg_rdata),
    .store_tensor_row_rvalid (rvalid),
    .store_tensor_row_rlast  (rlast),
    .store_tensor_row_rready (rready),
    .store_tensor_row_rdata  (rdata),
    .status_pad              (status_pad),
    .status_trunc            (status_trunc),
    .dbg_state               (dbg_state)
  );

  function automatic logic [BW-1:0] row_val(input int k);
    logic [BW-1:0] r;
    for (int j = 0; j < N; j++) r[j*SW +: SW] = 32'hA500_0000 | (k << 8) | j;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // mreg model: rotates one row per accepted move, reloaded to home on request
  assign mreg_rdata = row_val(int'(head));
  always @(posedge clk) begin
    if (mreg_reload) head <= 2'd0;
    else if (!rst && enable && renable) begin
      head      <= head + 2'd1;
      pop_total <= pop_total + 1;
    end
  end

  // output monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (!rready) chk("rdata_zero_when_not_ready", rdata, '0);
      if (enable && rvalid && rready) begin
        xfer_total++;
        chk("xfer_expected", BW'(exp_q.size() != 0), BW'(1));
        if (exp_q.size() != 0) chk("rdata", rdata, exp_q.pop_front());
      end
    end
  end

  // mode 0: rvalid held, 1: rvalid 1,0,0 pattern, 2: random rvalid and enable
  task automatic run_req(input int m1, input int rlast_at, input int mode, input bit hold);
    int p0, x0, cyc, nr;
    nr = m1 + 1;
    for (int k = 0; k < rlast_at; k++) exp_q.push_back(k < nr ? row_val(k) : '0);
    chk("wready_idle", BW'(wready), BW'(1));
    chk("busy_idle", BW'(busy), BW'(0));
    p0 = pop_total;
    x0 = xfer_total;
    wrequest = 1'b1;
    wnum = 2'(m1);
    enable = 1'b1;
    rvalid = 1'b0;
    rlast = 1'b0;
    @(posedge clk); #1;
    mreg_reload = 1'b0;
    if (!hold) wrequest = 1'b0;
    cyc = 0;
    while ((xfer_total - x0) < rlast_at && cyc < 200) begin
      if (hold) wnum = 2'($urandom_range(0, 3));
      if (cyc == 0 || mode == 0) rvalid = 1'b1;
      else if (mode == 1) rvalid = (cyc % 3 == 0);
      else rvalid = 1'($urandom_range(0, 1));
      enable = (cyc == 0 || mode != 2) ? 1'b1 : ($urandom_range(0, 3) != 0);
      rlast = ((xfer_total - x0) == rlast_at - 1);
      @(negedge clk);
      if (cyc == 0) begin
        chk("busy_t1", BW'(busy), BW'(1));
        chk("renable_t1", BW'(renable), BW'(1));
`ifdef DCA_MREG2STORE_OUTPUT_REG_EN
        chk("rready_t1", BW'(rready), BW'(0));
`else
        chk("rready_t1", BW'(rready), BW'(1));
`endif
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk("xfer_count", BW'(xfer_total - x0), BW'(rlast_at));
    wrequest = 1'b0;
    rvalid = 1'b0;
    rlast = 1'b0;
    enable = 1'b1;
    cyc = 0;
    @(negedge clk);
    while (busy && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("end_state_idle", BW'(dbg_state), BW'(0));
    chk("end_busy", BW'(busy), BW'(0));
    chk("pop_count", BW'(pop_total - p0), BW'(N));
    chk("mreg_home", BW'(head), BW'(0));
    chk("status_pad", BW'(status_pad), BW'(rlast_at > nr));
    chk("status_trunc", BW'(status_trunc), BW'(rlast_at < nr));
    chk("scoreboard_empty", BW'(exp_q.size()), BW'(0));
    exp_q.delete();
    @(posedge clk); #1;
  endtask

  task automatic start_two_pops();
    int p0, cyc;
    for (int k = 0; k < N; k++) exp_q.push_back(row_val(k));
    p0 = pop_total;
    wrequest = 1'b1;
    wnum = 2'd3;
    enable = 1'b1;
    rvalid = 1'b1;
    rlast = 1'b0;
    @(posedge clk); #1;
    mreg_reload = 1'b0;
    wrequest = 1'b0;
    cyc = 0;
    while ((pop_total - p0) < 2 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("two_pops", BW'(pop_total - p0), BW'(2));
    rvalid = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_state"}, BW'(dbg_state), BW'(0));
    chk({tag, "_busy"}, BW'(busy), BW'(0));
    chk({tag, "_wready"}, BW'(wready), BW'(1));
    chk({tag, "_renable"}, BW'(renable), BW'(0));
    chk({tag, "_rready"}, BW'(rready), BW'(0));
    chk({tag, "_rdata"}, rdata, '0);
    chk({tag, "_pad"}, BW'(status_pad), BW'(0));
    chk({tag, "_trunc"}, BW'(status_trunc), BW'(0));
  endtask

  initial begin
    clear = 1'b0;
    enable = 1'b0;
    wrequest = 1'b0;
    wnum = 2'd0;
    rvalid = 1'b0;
    rlast = 1'b0;
    mreg_reload = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    run_req(3, 4, 0, 1'b0);   // full read
    run_req(1, 2, 0, 1'b0);   // short request
    run_req(3, 2, 0, 1'b0);   // early rlast
    run_req(1, 4, 0, 1'b0);   // over-read
    run_req(3, 4, 1, 1'b0);   // back-pressure
    run_req(2, 5, 1, 1'b0);
    run_req(0, 1, 0, 1'b0);
    run_req(0, 3, 1, 1'b0);
    for (int i = 0; i < 8; i++)
      run_req($urandom_range(0, 3), $urandom_range(1, 6), 2, 1'b1);

    // clear mid-request, then a new request on the following cycle
    start_two_pops();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    mreg_reload = 1'b1;
    @(negedge clk);
    exp_q.delete();
    chk_idle_outputs("after_clear");
    run_req(3, 4, 0, 1'b0);

    // clear wins over a simultaneous request
    wrequest = 1'b1;
    clear = 1'b1;
    @(posedge clk); #1;
    wrequest = 1'b0;
    clear = 1'b0;
    @(negedge clk);
    chk("clear_beats_req_busy", BW'(busy), BW'(0));
    chk("clear_beats_req_state", BW'(dbg_state), BW'(0));
    @(posedge clk); #1;

    // asynchronous reset mid-request
    start_two_pops();
    #2;
    rst = 1'b1;
    #1;
    chk_idle_outputs("async_reset");
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    mreg_reload = 1'b1;
    @(posedge clk); #1;
    run_req(1, 4, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
